instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the core's instruction decode/datapath. Holds the PC and

---
 rtl/risc_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the instruction fetch stage.
package risc_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through prefetch FIFO of {instr, pc} entries with synchronous clear.
module fetch_fifo
    import risc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clear,
    input  fetch_entry_t            wdata,
    output fetch_entry_t            rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; an entry is only visible once written, because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited memory reads, buffers responses in order
// and discards responses that were in flight when the core redirected.
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int              XLEN       = risc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            arst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e     state;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  rsp_pc;
    logic [XLEN-1:0]  redirect_target;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    outstanding_after_rsp;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    drop_cnt_nxt;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             req_fire;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign redirect_target = word_align(redirect_pc);

    // Buffered plus in-flight words may never exceed the FIFO, so every response has a slot.
    assign imem_req_valid = (state == RUN)
                         && (({1'b0, fifo_count} + {1'b0, outstanding}) < CREDITS)
                         && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign outstanding_after_rsp = outstanding - CW'(imem_rsp_valid);
    assign push       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop        = !fifo_empty && instr_ready;
    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

    always_comb begin
        drop_cnt_nxt = drop_cnt;
        if (redirect_valid) begin
            drop_cnt_nxt = outstanding_after_rsp;
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt_nxt = drop_cnt - CW'(1);
        end
    end

    // NOTE: all state updates are non-blocking so every term above sees pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_after_rsp + CW'(req_fire);
            drop_cnt    <= drop_cnt_nxt;

            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
            end

            unique case (state)
                BOOT:    state <= RUN;
                RUN:     if (redirect_valid && (outstanding_after_rsp != '0)) state <= FLUSH;
                FLUSH:   if (!redirect_valid && (drop_cnt_nxt == '0)) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (push),
        .pop    (pop),
        .clear  (redirect_valid),
        .wdata  (push_entry),
        .rdata  (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? NOP_INSTR : head.instr;
    assign instr_pc    = fifo_empty ? '0 : head.pc;

    push_into_full_fifo: assert property (@(posedge clk) disable iff (!arst_n)
        !(push && fifo_full));
    outstanding_bounded: assert property (@(posedge clk) disable iff (!arst_n)
        (outstanding <= CW'(FIFO_DEPTH)) && (drop_cnt <= CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench: a latency-configurable memory model plus an architectural reference
// (sequential PC stream restarted by every redirect) that every fetched word is checked against.
module tb_instr_fetch_unit;
    import risc_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc, last_due, n_req, n_pop, first_valid_cyc;
    int          ready_pct = 100, pop_pct = 100, lat_min = 1, lat_max = 1;
    int          req_limit = 1 << 30;
    logic [31:0] exp_req_addr, exp_instr_pc, hs_addr;
    bit          hs_seen, prev_wait;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        pq.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_instr_pc", instr_pc, 0);
        @(posedge clk);
        #2 arst_n = 1'b1;
        cyc = 0;
        last_due = 0;
        n_req = 0;
        n_pop = 0;
        first_valid_cyc = -1;
        exp_req_addr = RST_PC;
        exp_instr_pc = RST_PC;
        prev_wait = 1'b0;
        hs_seen = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the reference, advance the model.
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit fire;
        int due;
        @(negedge clk);
        imem_req_ready = (n_req < req_limit) && ($urandom_range(99) < 32'(ready_pct));
        instr_ready    = ($urandom_range(99) < 32'(pop_pct));
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rsp_valid = (pq.size() > 0) && (pq[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? mem_word(pq[0].addr) : 32'hDEAD_BEEF;
        #1;
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!instr_valid) begin
            check("idle_instr", instr, NOP_INSTR);
            check("idle_instr_pc", instr_pc, 0);
        end else if (instr_ready) begin
            check("instr_pc", instr_pc, exp_instr_pc);
            check("instr_data", instr, mem_word(exp_instr_pc));
            exp_instr_pc += 4;
            n_pop++;
        end
        if (redir) check("req_valid_on_redirect", 32'(imem_req_valid), 0);
        else if (prev_wait) check("req_valid_held", 32'(imem_req_valid), 1);
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_addr);
        fire    = imem_req_valid && imem_req_ready;
        hs_seen = fire;
        hs_addr = imem_req_addr;
        if (imem_rsp_valid) void'(pq.pop_front());
        if (fire) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pq.push_back('{imem_req_addr, due});
            exp_req_addr += 4;
            n_req++;
            check("outstanding_limit", 32'(pq.size() <= DEPTH), 1);
        end
        if (redir) begin
            exp_req_addr = {tgt[31:2], 2'b00};
            exp_instr_pc = {tgt[31:2], 2'b00};
        end
        prev_wait = imem_req_valid && !imem_req_ready;
        cyc++;
    endtask

    task automatic expect_hs(input string tag, input logic [31:0] exp, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            step(1'b0, '0);
            seen = hs_seen;
        end
        check({tag, "_seen"}, 32'(seen), 1);
        if (seen) check(tag, hs_addr, exp);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] exp, input int max_cyc);
        bit          seen = 1'b0;
        logic [31:0] pc = '0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            step(1'b0, '0);
            if (instr_valid) begin
                seen = 1'b1;
                pc   = instr_pc;
            end
        end
        check({tag, "_seen"}, 32'(seen), 1);
        if (seen) check(tag, pc, exp);
    endtask

    initial begin
        logic [31:0] held;

        // Streaming with an always-ready single-cycle memory.
        do_reset();
        repeat (12) step(1'b0, '0);
        check("s1_first_valid_cycle", 32'(first_valid_cyc), 3);
        check("s1_pops", 32'(n_pop), 9);

        // Core stalled: the credit limit caps issue at the FIFO depth.
        pop_pct = 0;
        do_reset();
        repeat (10) step(1'b0, '0);
        check("s2_req_count", 32'(n_req), DEPTH);
        check("s2_req_valid_idle", 32'(imem_req_valid), 0);
        pop_pct = 100;
        step(1'b0, '0);
        pop_pct = 0;
        step(1'b0, '0);
        check("s2_req_after_pop", 32'(imem_req_valid), 1);

        // Redirect with three requests in flight on a 3-cycle memory.
        pop_pct = 100;
        lat_min = 3;
        lat_max = 3;
        req_limit = 3;
        do_reset();
        repeat (4) step(1'b0, '0);
        step(1'b1, 32'h0000_0100);
        req_limit = 1 << 30;
        expect_head("s3_first_pc", 32'h0000_0100, 20);
        repeat (6) step(1'b0, '0);

        // Redirect coinciding with a response and a pop.
        lat_min = 1;
        lat_max = 1;
        do_reset();
        repeat (8) step(1'b0, '0);
        step(1'b1, 32'h0000_0400);
        check("s4_pop_in_redirect", 32'(instr_valid), 1);
        step(1'b0, '0);
        check("s4_fifo_empty", 32'(instr_valid), 0);
        check("s4_restart_valid", 32'(imem_req_valid), 1);
        check("s4_restart_addr", imem_req_addr, 32'h0000_0400);
        repeat (6) step(1'b0, '0);

        // Memory back-pressure, with a redirect inside the stall window.
        do_reset();
        repeat (8) step(1'b0, '0);
        ready_pct = 0;
        step(1'b0, '0);
        check("s5_valid_stalled", 32'(imem_req_valid), 1);
        held = imem_req_addr;
        step(1'b0, '0);
        check("s5_addr_held", imem_req_addr, held);
        step(1'b1, 32'h0000_0803);
        step(1'b0, '0);
        step(1'b0, '0);
        check("s5_valid_target", 32'(imem_req_valid), 1);
        check("s5_addr_target", imem_req_addr, 32'h0000_0800);
        ready_pct = 100;
        expect_hs("s5_first_req", 32'h0000_0800, 10);
        repeat (6) step(1'b0, '0);

        // Address wrap, then asynchronous reset while flushing.
        do_reset();
        repeat (6) step(1'b0, '0);
        step(1'b1, 32'hFFFF_FFFC);
        expect_hs("s6_wrap_first", 32'hFFFF_FFFC, 10);
        expect_hs("s6_wrap_second", 32'h0000_0000, 10);
        repeat (6) step(1'b0, '0);
        check("s6_wrap_delivered", 32'(exp_instr_pc >= 32'h4 && exp_instr_pc < 32'h100), 1);
        lat_min = 4;
        lat_max = 4;
        repeat (6) step(1'b0, '0);
        check("s6_in_flight", 32'(pq.size() > 0), 1);
        step(1'b1, 32'h0000_0200);
        @(negedge clk);
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        check("s6_rst_req_valid", 32'(imem_req_valid), 0);
        check("s6_rst_instr_valid", 32'(instr_valid), 0);
        check("s6_rst_instr", instr, NOP_INSTR);
        check("s6_rst_instr_pc", instr_pc, 0);
        do_reset();
        expect_head("s6_after_reset_pc", RST_PC, 20);

        // Randomized traffic with random redirect targets.
        ready_pct = 70;
        pop_pct = 60;
        lat_min = 1;
        lat_max = 4;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 5) step(1'b1, $urandom);
            else step(1'b0, '0);
        end
        check("rand_progress", 32'(n_pop > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
